// File: rtl/rs_slot.sv
// rs_slot: single-entry reservation-station slot with two-port CDB operand wakeup.
// Latency: dispatch-to-issue 1 cycle, CDB wakeup-to-issue 1 cycle; with RS_FAST_ISSUE_EN
//          a dispatch with both operands ready can issue combinationally in the same cycle.
// Backpressure: issue_valid holds with stable issue_* until issue_ready; dispatches to an
//          occupied slot are dropped and flagged on disp_drop in the following cycle.
module rs_slot #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             disp_valid,
  input  logic [75:0]      disp_data,
  output logic             empty,
  output logic             disp_drop,
  input  logic             cdb0_valid,
  input  logic [TAG_W-1:0] cdb0_tag,
  input  logic [31:0]      cdb0_value,
  input  logic             cdb1_valid,
  input  logic [TAG_W-1:0] cdb1_tag,
  input  logic [31:0]      cdb1_value,
  input  logic             flush,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [31:0]      issue_rs1,
  output logic [31:0]      issue_rs2,
  output logic [4:0]       issue_rd,
  output logic [4:0]       issue_alu_ctrl
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Stored instruction fields; an operand's vt holds its tag until valid, then its value.
  logic [31:0] rs1_vt;
  logic        rs1_v;
  logic [31:0] rs2_vt;
  logic        rs2_v;
  logic [4:0]  rd;
  logic [4:0]  alu_ctrl;
  logic        drop_q;

  // Dispatch payload unpacked.
  logic [31:0] d_rs1_vt;
  logic        d_rs1_v;
  logic [31:0] d_rs2_vt;
  logic        d_rs2_v;
  logic [4:0]  d_rd;
  logic [4:0]  d_alu_ctrl;

  assign d_rs2_vt   = disp_data[75:44];
  assign d_rs2_v    = disp_data[43];
  assign d_rs1_vt   = disp_data[42:11];
  assign d_rs1_v    = disp_data[10];
  assign d_rd       = disp_data[9:5];
  assign d_alu_ctrl = disp_data[4:0];

  // Wakeup source: the incoming payload while EMPTY (entry snoop), the stored fields otherwise.
  // One set of tag comparators therefore serves both the entry snoop and WAIT wakeup.
  logic [31:0] src1_vt;
  logic        src1_v;
  logic [31:0] src2_vt;
  logic        src2_v;
  logic        hit0_1, hit1_1, hit0_2, hit1_2;
  logic [31:0] wk1_vt;
  logic        wk1_v;
  logic [31:0] wk2_vt;
  logic        wk2_v;
  logic        both_rdy;

  // Operand wakeup against both CDB ports; port 0 takes precedence on a double match.
  always_comb begin
    src1_vt  = (state == S_EMPTY) ? d_rs1_vt : rs1_vt;
    src1_v   = (state == S_EMPTY) ? d_rs1_v  : rs1_v;
    src2_vt  = (state == S_EMPTY) ? d_rs2_vt : rs2_vt;
    src2_v   = (state == S_EMPTY) ? d_rs2_v  : rs2_v;

    hit0_1   = !src1_v && cdb0_valid && (cdb0_tag == src1_vt[TAG_W-1:0]);
    hit1_1   = !src1_v && cdb1_valid && (cdb1_tag == src1_vt[TAG_W-1:0]);
    hit0_2   = !src2_v && cdb0_valid && (cdb0_tag == src2_vt[TAG_W-1:0]);
    hit1_2   = !src2_v && cdb1_valid && (cdb1_tag == src2_vt[TAG_W-1:0]);

    wk1_vt   = hit0_1 ? cdb0_value : (hit1_1 ? cdb1_value : src1_vt);
    wk1_v    = src1_v | hit0_1 | hit1_1;
    wk2_vt   = hit0_2 ? cdb0_value : (hit1_2 ? cdb1_value : src2_vt);
    wk2_v    = src2_v | hit0_2 | hit1_2;
    both_rdy = wk1_v & wk2_v;
  end

  // Same-cycle bypass: a fully-ready dispatch into an empty slot can issue immediately.
  logic bypass;
`ifdef RS_FAST_ISSUE_EN
  assign bypass = (state == S_EMPTY) && disp_valid && !flush && both_rdy;
`else
  assign bypass = 1'b0;
`endif

  logic load;
  logic upd;

  // Next-state and field-update control; flush overrides everything else.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    upd       = 1'b0;
    case (state)
      S_EMPTY: begin
        if (disp_valid) begin
          if (bypass && issue_ready) begin
            // Consumed straight off the dispatch bus; nothing is stored.
            state_nxt = S_EMPTY;
          end else begin
            load      = 1'b1;
            state_nxt = both_rdy ? S_READY : S_WAIT;
          end
        end
      end
      S_WAIT: begin
        upd = 1'b1;
        if (both_rdy) begin
          state_nxt = S_READY;
        end
      end
      S_READY: begin
        if (issue_ready) begin
          state_nxt = S_EMPTY;
        end
      end
      default: begin
        state_nxt = S_EMPTY;
      end
    endcase
    if (flush) begin
      state_nxt = S_EMPTY;
      load      = 1'b0;
      upd       = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand/field storage; fields are left untouched on issue and flush so outputs hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_vt   <= '0;
      rs1_v    <= 1'b0;
      rs2_vt   <= '0;
      rs2_v    <= 1'b0;
      rd       <= '0;
      alu_ctrl <= '0;
    end else begin
      if (load || upd) begin
        rs1_vt <= wk1_vt;
        rs1_v  <= wk1_v;
        rs2_vt <= wk2_vt;
        rs2_v  <= wk2_v;
      end
      if (load) begin
        rd       <= d_rd;
        alu_ctrl <= d_alu_ctrl;
      end
    end
  end

  // One-cycle pulse flagging a dispatch that hit an occupied slot (not raised during flush).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= disp_valid && !flush && (state != S_EMPTY);
    end
  end

  assign empty     = (state == S_EMPTY);
  assign disp_drop = drop_q;

  // Issue port: stored fields, or the snooped dispatch payload when bypassing.
  always_comb begin
    issue_valid    = (state == S_READY) || bypass;
    issue_rs1      = rs1_vt;
    issue_rs2      = rs2_vt;
    issue_rd       = rd;
    issue_alu_ctrl = alu_ctrl;
    if (bypass) begin
      issue_rs1      = wk1_vt;
      issue_rs2      = wk2_vt;
      issue_rd       = d_rd;
      issue_alu_ctrl = d_alu_ctrl;
    end
  end

endmodule

// File: tb/tb_rs_slot.sv
// Bench for rs_slot: directed scenarios followed by randomized traffic,
// all compared every cycle against a behavioural model of the slot.
module tb_rs_slot;

  logic        clk;
  logic        rst_n;
  logic        disp_valid;
  logic [75:0] disp_data;
  logic        empty;
  logic        disp_drop;
  logic        cdb0_valid;
  logic [4:0]  cdb0_tag;
  logic [31:0] cdb0_value;
  logic        cdb1_valid;
  logic [4:0]  cdb1_tag;
  logic [31:0] cdb1_value;
  logic        flush;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_rs1;
  logic [31:0] issue_rs2;
  logic [4:0]  issue_rd;
  logic [4:0]  issue_alu_ctrl;

  int n_checks = 0;
  int n_fail   = 0;

  rs_slot #(.TAG_W(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .disp_valid     (disp_valid),
    .disp_data      (disp_data),
    .empty          (empty),
    .disp_drop      (disp_drop),
    .cdb0_valid     (cdb0_valid),
    .cdb0_tag       (cdb0_tag),
    .cdb0_value     (cdb0_value),
    .cdb1_valid     (cdb1_valid),
    .cdb1_tag       (cdb1_tag),
    .cdb1_value     (cdb1_value),
    .flush          (flush),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_rs1      (issue_rs1),
    .issue_rs2      (issue_rs2),
    .issue_rd       (issue_rd),
    .issue_alu_ctrl (issue_alu_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: an optional held instruction with two operands.
  bit        m_occ;
  bit [31:0] m_op [2];
  bit        m_ov [2];
  bit [4:0]  m_rd;
  bit [4:0]  m_alu;
  bit        m_drop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [75:0] pack(input bit v1, input bit [31:0] vt1,
                                       input bit v2, input bit [31:0] vt2,
                                       input bit [4:0] rdv, input bit [4:0] alu);
    return {vt2, v2, vt1, v1, rdv, alu};
  endfunction

  task automatic idle();
    disp_valid  = 1'b0;
    disp_data   = '0;
    cdb0_valid  = 1'b0;
    cdb0_tag    = '0;
    cdb0_value  = '0;
    cdb1_valid  = 1'b0;
    cdb1_tag    = '0;
    cdb1_value  = '0;
    flush       = 1'b0;
    issue_ready = 1'b0;
  endtask

  task automatic model_reset();
    m_occ  = 0;
    m_op[0] = 0; m_op[1] = 0;
    m_ov[0] = 0; m_ov[1] = 0;
    m_rd = 0; m_alu = 0; m_drop = 0;
  endtask

  // A waiting operand takes the broadcast value whose tag matches; port 0 first.
  task automatic model_wake(input int i);
    if (!m_ov[i]) begin
      if (cdb0_valid && cdb0_tag == m_op[i][4:0]) begin
        m_op[i] = cdb0_value; m_ov[i] = 1;
      end else if (cdb1_valid && cdb1_tag == m_op[i][4:0]) begin
        m_op[i] = cdb1_value; m_ov[i] = 1;
      end
    end
  endtask

  task automatic compare_all();
    bit exp_iv;
    exp_iv = m_occ && m_ov[0] && m_ov[1];
    check("empty", {31'b0, empty}, {31'b0, !m_occ});
    check("disp_drop", {31'b0, disp_drop}, {31'b0, m_drop});
    check("issue_valid", {31'b0, issue_valid}, {31'b0, exp_iv});
    if (exp_iv) begin
      check("issue_rs1", issue_rs1, m_op[0]);
      check("issue_rs2", issue_rs2, m_op[1]);
      check("issue_rd", {27'b0, issue_rd}, {27'b0, m_rd});
      check("issue_alu", {27'b0, issue_alu_ctrl}, {27'b0, m_alu});
    end
  endtask

  // Advance one clock: model consumes the current inputs, then outputs are compared.
  task automatic tick();
    bit iv;
    bit nd;
    iv = m_occ && m_ov[0] && m_ov[1];
    nd = 0;
    if (flush) begin
      m_occ = 0;
    end else if (!m_occ) begin
      if (disp_valid) begin
        m_op[0] = disp_data[42:11]; m_ov[0] = disp_data[10];
        m_op[1] = disp_data[75:44]; m_ov[1] = disp_data[43];
        m_rd = disp_data[9:5]; m_alu = disp_data[4:0];
        model_wake(0); model_wake(1);
        m_occ = 1;
      end
    end else begin
      if (disp_valid) nd = 1;
      if (iv && issue_ready) m_occ = 0;
      else begin
        model_wake(0); model_wake(1);
      end
    end
    m_drop = nd;
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compare_all();
    check("rst_rs1", issue_rs1, 32'h0);

    // Reset asserted while an instruction is waiting.
    disp_valid = 1; disp_data = pack(0, 32'd7, 1, 32'h5, 5'd1, 5'd2);
    tick();
    idle();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_empty", {31'b0, empty}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    check("rst_empty", {31'b0, empty}, 32'd1);
    check("rst_issue_valid", {31'b0, issue_valid}, 32'd0);
    check("rst_issue_rs1", issue_rs1, 32'h0);
    @(posedge clk); #1;

    // Both operands ready at dispatch.
    disp_valid = 1; disp_data = pack(1, 32'h11, 1, 32'h22, 5'd3, 5'd5);
    tick();
    check("rdy_iv", {31'b0, issue_valid}, 32'd1);
    check("rdy_rs1", issue_rs1, 32'h11);
    check("rdy_rs2", issue_rs2, 32'h22);
    idle(); issue_ready = 1;
    tick();
    check("rdy_empty_after_issue", {31'b0, empty}, 32'd1);

    // Wakeup from cdb1, two cycles after dispatch.
    idle(); disp_valid = 1; disp_data = pack(0, 32'd7, 1, 32'h5, 5'd4, 5'd6);
    tick();
    idle();
    tick();
    cdb1_valid = 1; cdb1_tag = 5'd7; cdb1_value = 32'hDEAD;
    tick();
    check("wk_iv", {31'b0, issue_valid}, 32'd1);
    check("wk_rs1", issue_rs1, 32'hDEAD);
    idle(); issue_ready = 1;
    tick();

    // Both operands wait on tag 3; both ports broadcast tag 3.
    idle(); disp_valid = 1; disp_data = pack(0, 32'd3, 0, 32'd3, 5'd8, 5'd9);
    tick();
    idle();
    cdb0_valid = 1; cdb0_tag = 5'd3; cdb0_value = 32'hA;
    cdb1_valid = 1; cdb1_tag = 5'd3; cdb1_value = 32'hB;
    tick();
    check("dual_rs1", issue_rs1, 32'hA);
    check("dual_rs2", issue_rs2, 32'hA);
    idle(); issue_ready = 1;
    tick();

    // Entry snoop.
    idle(); disp_valid = 1; disp_data = pack(1, 32'h1, 0, 32'd9, 5'd2, 5'd1);
    cdb0_valid = 1; cdb0_tag = 5'd9; cdb0_value = 32'h77;
    tick();
    check("snoop_iv", {31'b0, issue_valid}, 32'd1);
    check("snoop_rs2", issue_rs2, 32'h77);
    idle(); issue_ready = 1;
    tick();

    // Dispatch while occupied, then flush with a concurrent dispatch.
    idle(); disp_valid = 1; disp_data = pack(0, 32'd4, 1, 32'h9, 5'd10, 5'd11);
    tick();
    disp_data = pack(1, 32'h1234, 1, 32'h5678, 5'd12, 5'd13);
    tick();
    check("drop_pulse", {31'b0, disp_drop}, 32'd1);
    check("drop_still_wait", {31'b0, issue_valid}, 32'd0);
    idle();
    tick();
    check("drop_cleared", {31'b0, disp_drop}, 32'd0);
    disp_valid = 1; flush = 1;
    tick();
    check("flush_empty", {31'b0, empty}, 32'd1);
    check("flush_no_drop", {31'b0, disp_drop}, 32'd0);
    idle();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      bit v1, v2;
      bit [31:0] a, b;
      v1 = $urandom_range(0, 1);
      v2 = $urandom_range(0, 1);
      a = $urandom; b = $urandom;
      if (!v1) a[4:0] = 5'($urandom_range(0, 7));
      if (!v2) b[4:0] = 5'($urandom_range(0, 7));
      disp_valid  = ($urandom_range(0, 1) == 1);
      disp_data   = pack(v1, a, v2, b, 5'($urandom), 5'($urandom));
      cdb0_valid  = ($urandom_range(0, 2) == 0);
      cdb0_tag    = 5'($urandom_range(0, 7));
      cdb0_value  = $urandom;
      cdb1_valid  = ($urandom_range(0, 2) == 0);
      cdb1_tag    = 5'($urandom_range(0, 7));
      cdb1_value  = $urandom;
      flush       = ($urandom_range(0, 15) == 0);
      issue_ready = ($urandom_range(0, 1) == 1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
